rom_user_id_top_module: RTL and testbench

ROM_USER_ID_TOP_MODULE -- requirements
Module: rom_user_id_top_module

---
 rtl/rom_user_id_top_module_pkg.sv | 22 ++
 rtl/rom_user_id_top_module_user_id_rom.sv | 22 ++
 rtl/rom_user_id_top_module.sv | 138 +++++++++++++
 tb/tb_rom_user_id_top_module.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rom_user_id_top_module_pkg.sv
// Shared types and constants for the user-login controller: FSM states,
// the ID-ROM contents and the default timing/lockout parameters.
package rom_user_id_top_module_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_GRANTED = 3'd2,
    ST_DENIED  = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  localparam int unsigned DENY_CYCLES_DEF = 4;
  localparam int unsigned MAX_FAILS_DEF   = 3;

  // Entry [i] is the board user ID that maps to internal index i.
  localparam logic [7:0][3:0] ID_ROM_TABLE = {
    4'b1000, 4'b0111, 4'b0110, 4'b0101,
    4'b0100, 4'b0011, 4'b0010, 4'b0001
  };

endpackage

// File: rtl/rom_user_id_top_module_user_id_rom.sv
// Combinational ID ROM: translates a 4-bit board user ID into a 3-bit
// internal index, flagging IDs that are not in the table.
module user_id_rom
  import rom_user_id_top_module_pkg::*;
(
  input  logic [3:0] user_id,
  output logic [2:0] index,
  output logic       valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ID_ROM_TABLE[i] == user_id) begin
        index = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_user_id_top_module.sv
// User login controller: edge-detects login/logout requests, looks the
// captured ID up in the ID ROM and grants, refuses or locks out the user.
//
// state   | meaning
// IDLE    | waiting for a login request
// CHECK   | one-clock ROM lookup of the captured ID
// GRANTED | user logged in, RAM enabled, waiting for logout
// DENIED  | refusal shown on red LED for DENY_CYCLES clocks
// LOCKED  | too many consecutive invalid IDs, only reset exits
module rom_user_id_top_module
  import rom_user_id_top_module_pkg::*;
#(
  parameter int unsigned DENY_CYCLES = DENY_CYCLES_DEF,
  parameter int unsigned MAX_FAILS   = MAX_FAILS_DEF
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] toggle_entry,
  input  logic       auth_button,
  input  logic [6:0] status,
  input  logic       log_out,
  output logic [2:0] internal_id,
  output logic       ROM_access,
  output logic       RAM_access,
  output logic       green_led_user,
  output logic       red_led_user
);

  localparam int unsigned DW = $clog2(DENY_CYCLES + 1);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam logic [DW-1:0] DENY_LOAD  = DW'(DENY_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  state_e          state_q, state_d;
  logic            auth_q, auth_d;
  logic            logout_q, logout_d;
  logic [3:0]      id_q, id_d;
  logic [2:0]      internal_id_q, internal_id_d;
  logic [DW-1:0]   deny_cnt_q, deny_cnt_d;
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;

  logic            auth_edge, logout_edge;
  logic [2:0]      rom_index;
  logic            rom_valid;
  logic            login_ok;
  logic            status_unused;

  assign auth_edge     = auth_button & ~auth_q;
  assign logout_edge   = log_out & ~logout_q;
  assign login_ok      = rom_valid & ~status[1];
  assign status_unused = ^{status[6:2], status[0]};

  user_id_rom u_rom (
    .user_id (id_q),
    .index   (rom_index),
    .valid   (rom_valid)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      auth_q        <= 1'b0;
      logout_q      <= 1'b0;
      id_q          <= '0;
      internal_id_q <= '0;
      deny_cnt_q    <= '0;
      fail_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      auth_q        <= auth_d;
      logout_q      <= logout_d;
      id_q          <= id_d;
      internal_id_q <= internal_id_d;
      deny_cnt_q    <= deny_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (auth_edge) state_d = ST_CHECK;
      ST_CHECK:   state_d = login_ok ? ST_GRANTED : ST_DENIED;
      ST_GRANTED: if (logout_edge) state_d = ST_IDLE;
      ST_DENIED: begin
        if (deny_cnt_q == '0)
          state_d = (fail_cnt_q >= FAIL_LIMIT) ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED:  state_d = ST_LOCKED;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Only invalid IDs count toward lockout; an inhibited valid ID does not.
  always_comb begin
    auth_d        = auth_button;
    logout_d      = log_out;
    id_d          = id_q;
    internal_id_d = internal_id_q;
    deny_cnt_d    = deny_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    case (state_q)
      ST_IDLE: if (auth_edge) id_d = toggle_entry;
      ST_CHECK: begin
        if (login_ok) begin
          internal_id_d = rom_index;
          fail_cnt_d    = '0;
        end else begin
          deny_cnt_d = DENY_LOAD;
          if (!rom_valid && fail_cnt_q != FAIL_LIMIT)
            fail_cnt_d = fail_cnt_q + FW'(1);
        end
      end
      ST_GRANTED: if (logout_edge) internal_id_d = '0;
      ST_DENIED: if (deny_cnt_q != '0) deny_cnt_d = deny_cnt_q - DW'(1);
      default: ;
    endcase
  end

  always_comb begin
    internal_id    = '0;
    ROM_access     = 1'b0;
    RAM_access     = 1'b0;
    green_led_user = 1'b0;
    red_led_user   = 1'b0;
    case (state_q)
      ST_CHECK: ROM_access = 1'b1;
      ST_GRANTED: begin
        internal_id    = internal_id_q;
        RAM_access     = 1'b1;
        green_led_user = 1'b1;
      end
      ST_DENIED, ST_LOCKED: red_led_user = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_user_id_top_module.sv
// Bench for the login controller: a table of login attempts plus
// hand-written sequences, checked cycle by cycle through an expected queue.
module tb_rom_user_id_top_module;

  logic       clock = 1'b0;
  logic       rst;
  logic [3:0] toggle_entry;
  logic       auth_button;
  logic [6:0] status;
  logic       log_out;
  logic [2:0] internal_id;
  logic       ROM_access, RAM_access, green_led_user, red_led_user;

  always #5 clock = ~clock;

  rom_user_id_top_module dut (
    .clock          (clock),
    .rst            (rst),
    .toggle_entry   (toggle_entry),
    .auth_button    (auth_button),
    .status         (status),
    .log_out        (log_out),
    .internal_id    (internal_id),
    .ROM_access     (ROM_access),
    .RAM_access     (RAM_access),
    .green_led_user (green_led_user),
    .red_led_user   (red_led_user)
  );

  typedef struct {
    logic [3:0] tog;
    logic [6:0] st;
    logic       grant;
    logic [2:0] id;
    logic       lock_after;
  } vec_t;

  vec_t       vecs[14];
  logic [6:0] exp_q[$];
  logic [6:0] act;
  int         total = 0;
  int         bad = 0;

  assign act = {internal_id, ROM_access, RAM_access, green_led_user, red_led_user};

  function automatic logic [6:0] pk(input logic [2:0] id, input logic rom,
                                    input logic ram, input logic grn, input logic red);
    return {id, rom, ram, grn, red};
  endfunction

  localparam logic [6:0] O_IDLE = 7'b000_0000;
  localparam logic [6:0] O_ROM  = 7'b000_1000;
  localparam logic [6:0] O_RED  = 7'b000_0001;

  task automatic check(input string name);
    logic [6:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, actual=%b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: actual id=%0d rom=%b ram=%b grn=%b red=%b, required id=%0d rom=%b ram=%b grn=%b red=%b",
                 name, act[6:4], act[3], act[2], act[1], act[0],
                 e[6:4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic cyc(input logic a, input logic lo, input logic [6:0] e, input string name);
    auth_button = a;
    log_out     = lo;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    check(name);
  endtask

  task automatic attempt(input vec_t v, input string name);
    toggle_entry = v.tog;
    status       = v.st;
    cyc(1'b1, 1'b0, O_ROM, {name, "_check"});
    if (v.grant) begin
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, pk(v.id, 0, 1, 1, 0), {name, "_grant"});
      cyc(1'b0, 1'b1, O_IDLE, {name, "_logout"});
      cyc(1'b0, 1'b0, O_IDLE, {name, "_idle"});
    end else begin
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, O_RED, {name, "_deny"});
      cyc(1'b0, 1'b0, v.lock_after ? O_RED : O_IDLE, {name, "_after"});
    end
  endtask

  // Called at a negedge; asserts reset between clock edges.
  task automatic async_reset(input string name);
    #2;
    rst = 1'b0;
    exp_q.push_back(O_IDLE);
    #1;
    check(name);
    @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b1100, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{4'b1100, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{4'b0110, 7'b0000000, 1'b1, 3'd5, 1'b0};
    vecs[3]  = '{4'b0001, 7'b0000000, 1'b1, 3'd0, 1'b0};
    vecs[4]  = '{4'b1000, 7'b0000000, 1'b1, 3'd7, 1'b0};
    vecs[5]  = '{4'b0000, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[6]  = '{4'b1111, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{4'b0110, 7'b0000010, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{4'b0111, 7'b1111101, 1'b1, 3'd6, 1'b0};
    vecs[9]  = '{4'b1001, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[10] = '{4'b0110, 7'b0000010, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{4'b1010, 7'b0000000, 1'b0, 3'd0, 1'b0};
    vecs[12] = '{4'b0011, 7'b0000010, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{4'b1100, 7'b0000000, 1'b0, 3'd0, 1'b1};

    rst          = 1'b0;
    toggle_entry = 4'b0000;
    auth_button  = 1'b0;
    status       = 7'b0;
    log_out      = 1'b0;
    #1;
    exp_q.push_back(O_IDLE);
    check("reset_state");
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    cyc(1'b0, 1'b0, O_IDLE, "idle_after_reset");

    for (int k = 0; k < 14; k++) attempt(vecs[k], $sformatf("vec%0d", k));

    // Locked: a valid login and a logout are ignored.
    toggle_entry = 4'b0110;
    status       = 7'b0;
    cyc(1'b1, 1'b0, O_RED, "locked_auth");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, O_RED, "locked_hold");
    cyc(1'b0, 1'b1, O_RED, "locked_logout");
    cyc(1'b0, 1'b0, O_RED, "locked_hold2");
    async_reset("reset_from_locked");
    cyc(1'b0, 1'b0, O_IDLE, "idle_after_unlock");

    // Granted user ignores further auth pulses and toggle changes.
    toggle_entry = 4'b0110;
    cyc(1'b1, 1'b0, O_ROM, "g_check");
    cyc(1'b0, 1'b0, pk(3'd5, 0, 1, 1, 0), "g_grant");
    toggle_entry = 4'b0111;
    cyc(1'b1, 1'b0, pk(3'd5, 0, 1, 1, 0), "g_auth_0111");
    cyc(1'b0, 1'b0, pk(3'd5, 0, 1, 1, 0), "g_hold");
    toggle_entry = 4'b1000;
    cyc(1'b1, 1'b0, pk(3'd5, 0, 1, 1, 0), "g_auth_1000");
    cyc(1'b0, 1'b0, pk(3'd5, 0, 1, 1, 0), "g_hold2");
    cyc(1'b0, 1'b1, O_IDLE, "g_logout");
    cyc(1'b0, 1'b0, O_IDLE, "g_idle");

    // Logout edge alone in IDLE does nothing.
    cyc(1'b0, 1'b1, O_IDLE, "idle_logout");
    cyc(1'b0, 1'b0, O_IDLE, "idle_logout2");

    // Simultaneous auth and logout edges in IDLE: auth wins.
    toggle_entry = 4'b0001;
    cyc(1'b0, 1'b0, O_IDLE, "sim_prep");
    cyc(1'b1, 1'b1, O_ROM, "sim_check");
    cyc(1'b0, 1'b0, pk(3'd0, 0, 1, 1, 0), "sim_grant");
    cyc(1'b0, 1'b1, O_IDLE, "sim_logout");

    // Toggle changed after the auth edge is not used.
    toggle_entry = 4'b0010;
    cyc(1'b1, 1'b0, O_ROM, "late_check");
    toggle_entry = 4'b1111;
    cyc(1'b0, 1'b0, pk(3'd1, 0, 1, 1, 0), "late_grant");
    cyc(1'b0, 1'b0, pk(3'd1, 0, 1, 1, 0), "late_hold");

    // Reset while granted aborts the session.
    async_reset("reset_mid_granted");
    cyc(1'b0, 1'b0, O_IDLE, "idle_after_abort");

    // Held auth level produces a single attempt.
    toggle_entry = 4'b1100;
    cyc(1'b1, 1'b0, O_ROM, "lvl_check");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, O_RED, "lvl_deny");
    cyc(1'b1, 1'b0, O_IDLE, "lvl_idle");
    cyc(1'b1, 1'b0, O_IDLE, "lvl_idle2");
    cyc(1'b0, 1'b0, O_IDLE, "lvl_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
